// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: keycode width, buffer defaults
// and the keycode map used by keypad, key_event_fifo and calc_logic.
package calc_pkg;

    localparam int KEYCODE_W      = 5;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int HOLDOFF_DEF    = 250000;

    typedef logic [KEYCODE_W-1:0] keycode_t;

    localparam keycode_t KEY_0   = 5'h00;
    localparam keycode_t KEY_1   = 5'h01;
    localparam keycode_t KEY_2   = 5'h02;
    localparam keycode_t KEY_3   = 5'h03;
    localparam keycode_t KEY_4   = 5'h04;
    localparam keycode_t KEY_5   = 5'h05;
    localparam keycode_t KEY_6   = 5'h06;
    localparam keycode_t KEY_7   = 5'h07;
    localparam keycode_t KEY_8   = 5'h08;
    localparam keycode_t KEY_9   = 5'h09;
    localparam keycode_t KEY_ADD = 5'h0A;
    localparam keycode_t KEY_SUB = 5'h0B;
    localparam keycode_t KEY_MUL = 5'h0C;
    localparam keycode_t KEY_DIV = 5'h0D;
    localparam keycode_t KEY_EQ  = 5'h0E;
    localparam keycode_t KEY_CLR = 5'h0F;

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_fifo_if.sv
// Key event stream: scanner-side push (newkey/keycode) and consumer-side
// show-ahead valid/ready, grouped so the FIFO sits between them as the slave.
interface key_event_fifo_if import calc_pkg::*; #(parameter int KW = KEYCODE_W);

    logic          newkey;
    logic [KW-1:0] keycode;
    logic          key_ready;
    logic          key_valid;
    logic [KW-1:0] key_code;

    modport master (output newkey, keycode, key_ready, input key_valid, key_code);
    modport slave  (input newkey, keycode, key_ready, output key_valid, key_code);

endinterface

// File: rtl/key_holdoff_timer.sv
// Same-key rejection window: reloads to HOLDOFF-1 on every accepted event and
// counts down to zero, where it parks until the next load.
module key_holdoff_timer import calc_pkg::*; #(
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic cnt_zero
);

    localparam int            CW       = cnt_width(HOLDOFF);
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLDOFF - 1);

    logic [CW-1:0] cnt_r;

    // Window counter: load wins, otherwise saturating decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/key_event_fifo.sv
// Keypad event buffer with same-key hold-off filter, show-ahead output stream,
// fill level and sticky overflow flag.
module key_event_fifo import calc_pkg::*; #(
    parameter int DEPTH   = FIFO_DEPTH_DEF,
    parameter int KW      = KEYCODE_W,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    key_event_fifo_if.slave            kif,
    input  logic                       flush,
    input  logic                       clr_drop,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       drop_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [KW-1:0] mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [LW-1:0] count_r;
    logic          valid_r;
    logic          drop_r;
    logic [KW-1:0] last_code_r;
    logic          last_vld_r;

    logic          cnt_zero_s;
    logic          cand_s;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic [LW-1:0] count_next_s;

    key_holdoff_timer #(.HOLDOFF(HOLDOFF)) u_holdoff (
        .clock    (clock),
        .reset    (reset),
        .load     (cand_s),
        .cnt_zero (cnt_zero_s)
    );

    // A repeat of the last accepted code inside the window is silently ignored.
    assign cand_s = kif.newkey & ~(last_vld_r & (kif.keycode == last_code_r) & ~cnt_zero_s);
    assign pop_s  = valid_r & kif.key_ready;
    assign full_s = (count_r == LW'(DEPTH));
    assign push_s = cand_s & (~full_s | pop_s) & ~flush;
    assign drop_s = cand_s & full_s & ~pop_s & ~flush;

    // Next occupancy; flush overrides any concurrent push or pop.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = {LW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + LW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - LW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Occupancy and registered valid, kept in step so key_valid has no input path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {LW{1'b0}};
            valid_r <= 1'b0;
        end else begin
            count_r <= count_next_s;
            valid_r <= (count_next_s != {LW{1'b0}});
        end
    end

    // Read/write pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= kif.keycode;
        end
    end

    // Sticky overflow flag; a new drop beats a concurrent clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else if (drop_s) begin
            drop_r <= 1'b1;
        end else if (clr_drop) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Remember the last candidate code, whether it was stored, dropped or flushed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_code_r <= {KW{1'b0}};
            last_vld_r  <= 1'b0;
        end else if (cand_s) begin
            last_code_r <= kif.keycode;
            last_vld_r  <= 1'b1;
        end else begin
            last_code_r <= last_code_r;
            last_vld_r  <= last_vld_r;
        end
    end

    assign kif.key_valid = valid_r;
    assign kif.key_code  = mem_r[rd_ptr_r];
    assign level         = count_r;
    assign drop_flag     = drop_r;

endmodule

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench for key_event_fifo: directed scenarios followed by random
// traffic, compared against a timestamp/queue model of the event rules.
module tb_key_event_fifo;
    import calc_pkg::*;

    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 4;
    localparam int KW      = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          clr_drop = 1'b0;
    logic [2:0]    level;
    logic          drop_flag;

    key_event_fifo_if #(.KW(KW)) kif();

    key_event_fifo #(.DEPTH(DEPTH), .KW(KW), .HOLDOFF(HOLDOFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .kif       (kif),
        .flush     (flush),
        .clr_drop  (clr_drop),
        .level     (level),
        .drop_flag (drop_flag)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of expected codes plus time-stamped hold-off.
    logic [KW-1:0] sb[$];
    int            mcount = 0;
    bit            mdrop = 1'b0;
    bit            mlast_vld = 1'b0;
    logic [KW-1:0] mlast = '0;
    int            mlast_cyc = 0;
    int            cyc = 0;
    int            exp_level = 0;
    bit            exp_drop = 1'b0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample away from the active edge, pop the scoreboard on each transfer.
    always @(negedge clock) begin
        logic [KW-1:0] exp_code;
        if (mon_en && !reset) begin
            check("level", int'(level), exp_level);
            check("key_valid", int'(kif.key_valid), int'(exp_level != 0));
            check("drop_flag", int'(drop_flag), int'(exp_drop));
            if (kif.key_valid && kif.key_ready && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL key_code: got %0h with no entry expected at %0t", kif.key_code, $time);
                end else begin
                    exp_code = sb.pop_front();
                    check("key_code", int'(kif.key_code), int'(exp_code));
                end
            end
        end
    end

    // Drive one cycle of inputs and advance the model by the same cycle.
    task automatic step(input bit nk, input logic [KW-1:0] code, input bit rdy,
                        input bit fl = 1'b0, input bit cd = 1'b0);
        bit supp, cand, pop, drop;
        kif.newkey    = nk;
        kif.keycode   = code;
        kif.key_ready = rdy;
        flush         = fl;
        clr_drop      = cd;
        exp_level     = mcount;
        exp_drop      = mdrop;
        supp = mlast_vld && (code == mlast) && ((cyc - mlast_cyc) < HOLDOFF);
        cand = nk && !supp;
        pop  = (mcount > 0) && rdy;
        drop = cand && !fl && (mcount == DEPTH) && !pop;
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (cand && !drop) begin
                sb.push_back(code);
                mcount++;
            end
            if (pop) mcount--;
        end
        if (drop) mdrop = 1'b1;
        else if (cd) mdrop = 1'b0;
        if (cand) begin
            mlast     = code;
            mlast_vld = 1'b1;
            mlast_cyc = cyc;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'h00, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'h00, 1'b1);
    endtask

    initial begin
        kif.newkey    = 1'b0;
        kif.keycode   = 5'h00;
        kif.key_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single press, then pop
        step(1'b1, 5'h07, 1'b0);
        idle(1);
        drain(1);
        idle(1);

        // Hold-off: repeat at +2 suppressed, repeat at +6 accepted
        idle(5);
        step(1'b1, 5'h03, 1'b0);
        idle(1);
        step(1'b1, 5'h03, 1'b0);
        idle(3);
        step(1'b1, 5'h03, 1'b0);
        idle(1);
        drain(3);
        // Different code passes immediately
        idle(5);
        step(1'b1, 5'h03, 1'b0);
        step(1'b1, 5'h04, 1'b0);
        idle(1);
        drain(3);

        // Overflow, drain order, clear drop
        idle(5);
        for (int c = 1; c <= 5; c++) step(1'b1, 5'(c), 1'b0);
        idle(1);
        drain(5);
        step(1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Full with simultaneous pop and push
        idle(5);
        for (int c = 1; c <= 4; c++) step(1'b1, 5'(c), 1'b0);
        idle(1);
        step(1'b1, 5'h09, 1'b1);
        idle(1);
        drain(5);

        // Flush with concurrent press, then same code inside the window
        idle(5);
        for (int c = 1; c <= 3; c++) step(1'b1, 5'(c), 1'b0);
        idle(1);
        step(1'b1, 5'h0A, 1'b1, 1'b1);
        idle(1);
        step(1'b1, 5'h0A, 1'b0);
        idle(2);

        // Asynchronous reset between edges
        idle(5);
        step(1'b1, 5'h0B, 1'b0);
        step(1'b1, 5'h0C, 1'b0);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", int'(kif.key_valid), 0);
        check("async_rst_level", int'(level), 0);
        sb.delete();
        mcount    = 0;
        mdrop     = 1'b0;
        mlast_vld = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b1, 5'h0C, 1'b0);
        idle(2);
        drain(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 2) == 0, 5'($urandom_range(1, 4)), ($urandom % 3) == 0,
                 ($urandom % 50) == 0, ($urandom % 20) == 0);
        end
        drain(DEPTH + 4);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
